keypoint_reader: RTL and testbench
==================================

# keypoint_reader

Drains the two keypoint SRAMs filled by the detect/filter stage (bank 1 = DoG layer pair 0, bank 2 = DoG layer pair 1) and streams every stored keypoint, bank 1 first, to the downstream orientation/descriptor stage over a valid/ready interface. It issues one synchronous SRAM read per cycle when the output can accept data and absorbs the 1-cycle SRAM latency with a 2-entry output buffer. Each keypoint is emitted as {row, col, layer}, and the last one is flagged.

## Interface
- ADDR_W, 11: keypoint SRAM address width (2K entries per bank)
- ROW_W, 9: row field width, bits [18:10] of an SRAM word
- COL_W, 10: column field width, bits [9:0] of an SRAM word
- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin draining; honoured only in IDLE
- kp1_count  in  ADDR_W+1  entries written to bank 1 (0..2048); sampled on the accepted start
- kp2_count  in  ADDR_W+1  entries written to bank 2; sampled on the accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final transfer, or after an empty run
- kp1_re  out  1  bank 1 read enable
- kp1_addr  out  ADDR_W  bank 1 read address
- kp1_dout  in  ROW_W+COL_W  bank 1 read data, valid one cycle after kp1_re
- kp2_re / kp2_addr / kp2_dout: same as bank 1, for bank 2
- kp_valid  out  1  output keypoint valid
- kp_ready  in  1  downstream accept
- kp_row  out  ROW_W  keypoint row
- kp_col  out  COL_W  keypoint column
- kp_layer  out  1  0 = bank 1, 1 = bank 2
- kp_last  out  1  marks the final keypoint of the run

## Operation
- FSM states: IDLE, RD1, RD2, DRAIN.
- **IDLE**
  - start=1: latch both counts, clamping each to 2048; go to RD1.
  - If both latched counts are 0, go straight to DRAIN.
- **RD1**
  - Issue a read (kp1_re=1, kp1_addr=rd_idx) when buffer occupancy + reads in flight < 2. At most one read is in flight.
  - rd_idx increments on each issue.
  - After issuing index kp1_count-1, or immediately if kp1_count=0: reset rd_idx to 0 and go to RD2.
- **RD2**
  - Same as RD1 on bank 2.
  - After the last issue, or if kp2_count=0: go to DRAIN.
- **DRAIN**
  - Wait until no read is in flight and the buffer is empty.
  - Then pulse done and return to IDLE.
- Returned data: the word arriving the cycle after a read is written into the 2-entry FIFO, tagged with its layer and a last flag.
  - last = this is the final issued read overall, i.e. the last bank 2 entry, or the last bank 1 entry when kp2_count=0.
- Output: kp_* always show the FIFO head. kp_valid = FIFO not empty. A transfer occurs on kp_valid && kp_ready.
- Word split: kp_row = dout[18:10], kp_col = dout[9:0]. No arithmetic on the fields.
- Backpressure: with kp_ready low, reads stop once occupancy + in-flight = 2. No entry is ever lost or duplicated.
- start while busy: ignored.
- Reset mid-run: every state element returns to its reset value on the next edge. Any in-flight SRAM data is discarded.

## Timing
- Reset values:
  - FSM in IDLE; rd_idx = 0; FIFO empty.
  - busy, done, kp1_re, kp2_re, kp_valid and kp_last are 0.
  - kp1_addr, kp2_addr, kp_row, kp_col and kp_layer are 0.
- Latency, start in cycle T with kp_ready held high:
  - First read in T+1.
  - Data captured at the end of T+2.
  - kp_valid=1 in T+3.
- Throughput: one keypoint per cycle with kp_ready high, including across the bank 1 → bank 2 switch.
- done: pulses in the cycle after the kp_last transfer. busy falls in that same cycle.
- Empty run (both counts 0): done in T+2, and kp_valid is never asserted.
- kp_* are stable while kp_valid && !kp_ready.
- kp1_re and kp2_re are never high in the same cycle.

## Test plan
- **Reset:** assert rst mid-run with kp_valid high → next cycle busy=0, kp_valid=0, and all outputs at reset values.
- **Normal run:** kp1_count=3 with words {5,7},{5,100},{6,639}; kp2_count=2 with {10,1},{479,2}; kp_ready=1.
  - Outputs in cycles T+3..T+7: (5,7,0), (5,100,0), (6,639,0), (10,1,1), (479,2,1).
  - kp_last only on the fifth; done in T+8.
- **Empty banks:**
  - kp1_count=0, kp2_count=1 → a single keypoint with layer=1, last=1, and kp1_re never asserted.
  - Both counts 0 → done in T+2.
- **Backpressure:** 4 keypoints with kp_ready toggling randomly (50%).
  - Exactly 4 transfers, in order, with no duplicates.
  - Never more than 2 reads ahead of consumption; kp_* stable while stalled.
- **Full bank:** kp1_count=2048, kp2_count=0.
  - Addresses 0..2047 each read exactly once; 2048 transfers; no address wrap.
- **start while busy:** pulse start mid-run with different counts.
  - The run completes with the original counts; exactly one done pulse.

Source files
------------

// File: rtl/keypoint_reader.sv
// Streams keypoints from two SRAM banks (bank 1 then bank 2) as {row, col, layer, last}.
// First keypoint valid 3 cycles after start; reads pause once buffered + in-flight words reach 2.
module keypoint_reader #(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [ADDR_W:0]        i_kp1_count,
    input  logic [ADDR_W:0]        i_kp2_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_kp1_re,
    output logic [ADDR_W-1:0]      o_kp1_addr,
    input  logic [ROW_W+COL_W-1:0] i_kp1_dout,
    output logic                   o_kp2_re,
    output logic [ADDR_W-1:0]      o_kp2_addr,
    input  logic [ROW_W+COL_W-1:0] i_kp2_dout,
    output logic                   o_kp_valid,
    input  logic                   i_kp_ready,
    output logic [ROW_W-1:0]       o_kp_row,
    output logic [COL_W-1:0]       o_kp_col,
    output logic                   o_kp_layer,
    output logic                   o_kp_last
);

    localparam int DAT_W = ROW_W + COL_W;
    localparam int ENT_W = DAT_W + 2;
    localparam logic [ADDR_W:0]   MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RD1, S_RD2, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_cnt1;
    logic [ADDR_W:0]   r_cnt2;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_inflight;
    logic              r_inflight_layer;
    logic              r_inflight_last;
    logic [ENT_W-1:0]  r_fifo [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_occ;

    logic              w_pop;
    logic [2:0]        w_pend;
    logic              w_room;
    logic              w_end1;
    logic              w_end2;
    logic              w_issue;
    logic              w_issue_last;
    logic [DAT_W-1:0]  w_rd_dat;
    logic [ENT_W-1:0]  w_head;

    assign w_pop  = o_kp_valid & i_kp_ready;
    // Count the word landing this cycle and credit this cycle's pop, so reads can run back to back.
    assign w_pend = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room = (w_pend < 3'd2);
    assign w_end1 = ({1'b0, r_rd_idx} == (r_cnt1 - CNT_ONE));
    assign w_end2 = ({1'b0, r_rd_idx} == (r_cnt2 - CNT_ONE));
    assign w_issue = o_kp1_re | o_kp2_re;
    assign w_issue_last = (o_kp2_re & w_end2) | (o_kp1_re & w_end1 & (r_cnt2 == '0));
    assign w_rd_dat = r_inflight_layer ? i_kp2_dout : i_kp1_dout;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RD1;
            S_RD1: begin
                if (r_cnt1 == '0)         w_next = (r_cnt2 == '0) ? S_DRAIN : S_RD2;
                else if (w_issue && w_end1) w_next = S_RD2;
            end
            S_RD2:   if ((r_cnt2 == '0) || (w_issue && w_end2)) w_next = S_DRAIN;
            S_DRAIN: if (!r_inflight && (r_occ == 2'd0)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_kp1_re   = (r_state == S_RD1) && (r_cnt1 != '0) && w_room;
        o_kp2_re   = (r_state == S_RD2) && (r_cnt2 != '0) && w_room;
        o_kp1_addr = (r_state == S_RD1) ? r_rd_idx : '0;
        o_kp2_addr = (r_state == S_RD2) ? r_rd_idx : '0;
        o_done     = (r_state == S_DRAIN) && !r_inflight && (r_occ == 2'd0);
        o_busy     = (r_state != S_IDLE) && !o_done;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt1           <= '0;
            r_cnt2           <= '0;
            r_rd_idx         <= '0;
            r_inflight       <= 1'b0;
            r_inflight_layer <= 1'b0;
            r_inflight_last  <= 1'b0;
            r_wptr           <= 1'b0;
            r_rptr           <= 1'b0;
            r_occ            <= 2'd0;
            for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_cnt1 <= (i_kp1_count > MAX_CNT) ? MAX_CNT : i_kp1_count;
                r_cnt2 <= (i_kp2_count > MAX_CNT) ? MAX_CNT : i_kp2_count;
            end
            if (w_issue) begin
                r_rd_idx <= ((o_kp1_re && w_end1) || (o_kp2_re && w_end2)) ? '0 : r_rd_idx + IDX_ONE;
            end
            r_inflight       <= w_issue;
            r_inflight_layer <= o_kp2_re;
            r_inflight_last  <= w_issue_last;
            if (r_inflight) begin
                r_fifo[r_wptr] <= {r_inflight_last, r_inflight_layer, w_rd_dat};
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign w_head     = r_fifo[r_rptr];
    assign o_kp_valid = (r_occ != 2'd0);
    assign o_kp_row   = w_head[DAT_W-1:COL_W];
    assign o_kp_col   = w_head[COL_W-1:0];
    assign o_kp_layer = w_head[DAT_W];
    assign o_kp_last  = w_head[DAT_W+1] & o_kp_valid;

endmodule

// File: tb/tb_keypoint_reader.sv
// Bench for keypoint_reader: SRAM models, transfer monitor and a list-based reference model.
module tb_keypoint_reader;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [11:0] kp1_count, kp2_count;
    logic        kp1_re, kp2_re;
    logic [10:0] kp1_addr, kp2_addr;
    logic [18:0] kp1_dout, kp2_dout;
    logic        kp_valid, kp_ready;
    logic [8:0]  kp_row;
    logic [9:0]  kp_col;
    logic        kp_layer, kp_last;

    always #5 clk = ~clk;

    keypoint_reader dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_kp1_count(kp1_count), .i_kp2_count(kp2_count),
        .o_busy(busy), .o_done(done),
        .o_kp1_re(kp1_re), .o_kp1_addr(kp1_addr), .i_kp1_dout(kp1_dout),
        .o_kp2_re(kp2_re), .o_kp2_addr(kp2_addr), .i_kp2_dout(kp2_dout),
        .o_kp_valid(kp_valid), .i_kp_ready(kp_ready),
        .o_kp_row(kp_row), .o_kp_col(kp_col), .o_kp_layer(kp_layer), .o_kp_last(kp_last)
    );

    logic [18:0] mem1 [2048];
    logic [18:0] mem2 [2048];

    always @(posedge clk) begin
        if (kp1_re) kp1_dout <= mem1[kp1_addr];
        if (kp2_re) kp2_dout <= mem2[kp2_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: transfers, read bookkeeping and protocol violations, cleared per run.
    logic        mon_clr;
    logic [20:0] got [$];
    logic [20:0] exp_q [$];
    int          rd_hits1 [2048];
    int          rd_hits2 [2048];
    int          issued, xfers, max_ahead, both_err, stab_err, done_cnt;
    bit          saw_valid, re1_seen, prev_stall;
    logic [21:0] prev_kp;

    always @(negedge clk) begin
        if (mon_clr) begin
            got.delete();
            for (int i = 0; i < 2048; i++) begin rd_hits1[i] = 0; rd_hits2[i] = 0; end
            issued = 0; xfers = 0; max_ahead = 0; both_err = 0; stab_err = 0; done_cnt = 0;
            saw_valid = 0; re1_seen = 0; prev_stall = 0;
        end else if (rst) begin
            prev_stall = 0;
        end else begin
            if (kp1_re) begin rd_hits1[kp1_addr]++; issued++; re1_seen = 1; end
            if (kp2_re) begin rd_hits2[kp2_addr]++; issued++; end
            if (kp1_re && kp2_re) both_err++;
            if (kp_valid) saw_valid = 1;
            if (kp_valid && kp_ready) begin
                got.push_back({kp_last, kp_layer, kp_row, kp_col});
                xfers++;
            end
            if (issued - xfers > max_ahead) max_ahead = issued - xfers;
            if (prev_stall && ({kp_valid, kp_last, kp_layer, kp_row, kp_col} !== prev_kp)) stab_err++;
            prev_stall = kp_valid && !kp_ready;
            prev_kp    = {kp_valid, kp_last, kp_layer, kp_row, kp_col};
            if (done) done_cnt++;
        end
    end

    // Reference: every stored word of bank 1 then bank 2, counts clamped to 2048, last on the final one.
    task automatic build_exp(input int c1, input int c2);
        int n1, n2;
        logic [20:0] e;
        n1 = (c1 > 2048) ? 2048 : c1;
        n2 = (c2 > 2048) ? 2048 : c2;
        exp_q.delete();
        for (int i = 0; i < n1; i++) exp_q.push_back({2'b00, mem1[i]});
        for (int i = 0; i < n2; i++) exp_q.push_back({2'b01, mem2[i]});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            e[20] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {16'd0, busy, done, kp1_re, kp2_re, kp_valid, kp_last, kp_layer,
                kp1_addr, kp2_addr, kp_row, kp_col};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    endtask

    task automatic run_kp(input string pfx, input int c1, input int c2, input bit rnd,
                          input int pulse_at, input int budget);
        int cyc, n_bad;
        bit seen;
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 19'($urandom);
            mem2[i] = 19'($urandom);
        end
        build_exp(c1, c2);
        clear_mon();
        start = 1'b1; kp1_count = 12'(c1); kp2_count = 12'(c2);
        kp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < budget) begin
            tick();
            start = 1'b0;
            cyc++;
            if (cyc == pulse_at) begin start = 1'b1; kp1_count = 12'd7; kp2_count = 12'd5; end
            kp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) seen = 1;
        end
        check({pfx, "_done_seen"}, 64'(seen), 64'd1);
        repeat (3) tick();
        n_bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) n_bad++;
        check({pfx, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        check({pfx, "_order"}, 64'(n_bad), 64'd0);
        check({pfx, "_one_done"}, 64'(done_cnt), 64'd1);
        check({pfx, "_ahead_le2"}, 64'(max_ahead <= 2), 64'd1);
        check({pfx, "_stable"}, 64'(stab_err), 64'd0);
        check({pfx, "_re_excl"}, 64'(both_err), 64'd0);
    endtask

    logic [20:0] nrm_exp [5];
    logic [21:0] kp_o [10];
    bit          v_o [10], d_o [10], b_o [10], r1_o [10];

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; kp1_count = '0; kp2_count = '0; kp_ready = 1'b0; mon_clr = 1'b0;
        for (int i = 0; i < 2048; i++) begin mem1[i] = '0; mem2[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", outs_vec(), 64'd0);

        // Directed run with cycle-exact timing.
        mem1[0] = {9'd5, 10'd7};  mem1[1] = {9'd5, 10'd100}; mem1[2] = {9'd6, 10'd639};
        mem2[0] = {9'd10, 10'd1}; mem2[1] = {9'd479, 10'd2};
        nrm_exp[0] = {2'b00, 9'd5, 10'd7};   nrm_exp[1] = {2'b00, 9'd5, 10'd100};
        nrm_exp[2] = {2'b00, 9'd6, 10'd639}; nrm_exp[3] = {2'b01, 9'd10, 10'd1};
        nrm_exp[4] = {2'b11, 9'd479, 10'd2};
        kp_ready = 1'b1;
        clear_mon();
        start = 1'b1; kp1_count = 12'd3; kp2_count = 12'd2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            v_o[k] = kp_valid; d_o[k] = done; b_o[k] = busy; r1_o[k] = kp1_re;
            kp_o[k] = {kp_valid, kp_last, kp_layer, kp_row, kp_col};
        end
        check("nrm_re1_T1", 64'(r1_o[1]), 64'd1);
        check("nrm_busy_T1", 64'(b_o[1]), 64'd1);
        check("nrm_valid_T2", 64'(v_o[2]), 64'd0);
        for (int k = 3; k <= 7; k++)
            check($sformatf("nrm_kp_T%0d", k), 64'(kp_o[k]), 64'({1'b1, nrm_exp[k-3]}));
        check("nrm_done_T7", 64'(d_o[7]), 64'd0);
        check("nrm_done_T8", 64'(d_o[8]), 64'd1);
        check("nrm_busy_T8", 64'(b_o[8]), 64'd0);
        check("nrm_valid_T8", 64'(v_o[8]), 64'd0);
        check("nrm_done_T9", 64'(d_o[9]), 64'd0);

        // Both banks empty.
        clear_mon();
        start = 1'b1; kp1_count = 12'd0; kp2_count = 12'd0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            d_o[k] = done;
        end
        tick();
        check("empty_done_T1", 64'(d_o[1]), 64'd0);
        check("empty_done_T2", 64'(d_o[2]), 64'd1);
        check("empty_done_T3", 64'(d_o[3]), 64'd0);
        check("empty_no_valid", 64'(saw_valid), 64'd0);

        // Bank 1 empty, one keypoint in bank 2.
        run_kp("b1empty", 0, 1, 1'b0, 0, 50);
        check("b1empty_head", 64'(got.size() > 0 ? got[0][20:19] : 2'b00), 64'd3);
        check("b1empty_no_re1", 64'(re1_seen), 64'd0);

        // Random backpressure.
        run_kp("bp_2_2", 2, 2, 1'b1, 0, 200);
        run_kp("bp_4_0", 4, 0, 1'b1, 0, 200);
        run_kp("bp_rand", $urandom_range(1, 12), $urandom_range(0, 12), 1'b1, 0, 400);

        // A second start mid-run must be ignored.
        run_kp("start_busy", 3, 2, 1'b1, 3, 200);

        // Reset while a keypoint is waiting on the output.
        clear_mon();
        start = 1'b1; kp1_count = 12'd10; kp2_count = 12'd10; kp_ready = 1'b0;
        bad = 1;
        for (int k = 0; k < 20 && bad != 0; k++) begin
            tick();
            start = 1'b0;
            @(negedge clk);
            if (kp_valid) bad = 0;
        end
        check("rstmid_valid_seen", 64'(bad), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_outputs", outs_vec(), 64'd0);
        tick();

        // Full bank 1, then a clamped bank 2.
        run_kp("full1", 2048, 0, 1'b0, 0, 3000);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (rd_hits1[i] != 1) bad++;
        check("full1_addr_once", 64'(bad), 64'd0);
        run_kp("clamp2", 0, 4095, 1'b0, 0, 3000);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (rd_hits2[i] != 1) bad++;
        check("clamp2_addr_once", 64'(bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
